// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard controller bus: decode/branch inputs plus stall/flush/issue and debug outputs.
// Ports: id_valid, id_ir, br_taken (pipeline -> controller); stall, flush, issue, busy_mask,
//        stall_cnt, flush_cnt (controller -> pipeline).  master = pipeline side, slave = controller.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [31:0]      id_ir;
   logic             br_taken;
   logic             stall;
   logic             flush;
   logic             issue;
   logic [31:0]      busy_mask;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_ir, br_taken,
      input  stall, flush, issue, busy_mask, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_ir, br_taken,
      output stall, flush, issue, busy_mask, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard/flush controller for a 5-stage pipeline; stall and issue are combinational
// from decode, flush is a registered window after a taken branch.
// Ports: clk, RN (async active-low reset), hz (slave modport of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl #(
   parameter int WB_LAT    = 3,
   parameter int FLUSH_LEN = 2,
   parameter int CNT_W     = 16
) (
   input logic               clk,
   input logic               RN,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int SB_W = $clog2(WB_LAT + 1);
   localparam int FC_W = $clog2(FLUSH_LEN + 1);

   // decode fields
   logic [6:0] op;
   logic [2:0] f3;
   logic [4:0] rd, rs1, rs2;
   logic       wr_en, rs1_en, rs2_en, rd_rd_en;

   assign op  = hz.id_ir[6:0];
   assign rd  = hz.id_ir[11:7];
   assign f3  = hz.id_ir[14:12];
   assign rs1 = hz.id_ir[19:15];
   assign rs2 = hz.id_ir[24:20];

   logic [6:0] unused_ir_bits;
   assign unused_ir_bits = hz.id_ir[31:25];

   always_comb begin
      wr_en    = 1'b0;
      rs1_en   = 1'b0;
      rs2_en   = 1'b0;
      rd_rd_en = 1'b0;
      case (op)
         7'd0, 7'd3: begin
            wr_en  = 1'b1;
            rs1_en = 1'b1;
            rs2_en = 1'b1;
         end
         7'd1: begin
            if (f3 == 3'd0) begin
               wr_en  = 1'b1;
               rs1_en = 1'b1;
            end else if (f3 == 3'd1) begin
               // store reads rd as its data operand
               rs1_en   = 1'b1;
               rs2_en   = 1'b1;
               rd_rd_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // state
   logic [SB_W-1:0]  sb_q [32];
   logic [SB_W-1:0]  sb_d [32];
   logic [FC_W-1:0]  fc_q, fc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [31:0] busy_w;
   logic        hazard_w, flush_w, stall_w, issue_w;

   always_comb begin
      busy_w = '0;
      for (int r = 1; r < 32; r++) begin
         busy_w[r] = (sb_q[r] != '0);
      end
   end

   // busy_w[0] is constant 0, so r0 sources never hazard
   assign hazard_w = (rs1_en & busy_w[rs1]) | (rs2_en & busy_w[rs2]) | (rd_rd_en & busy_w[rd]);
   assign flush_w  = (fc_q != '0);
   assign stall_w  = hz.id_valid & ~flush_w & hazard_w;
   // br_taken kills the branch's successor before fc has been loaded
   assign issue_w  = hz.id_valid & ~stall_w & ~flush_w & ~hz.br_taken;

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - SB_W'(1) : '0;
      end
      // new write (including WAW reload) overrides the decrement
      if (issue_w && wr_en && (rd != 5'd0)) begin
         sb_d[rd] = SB_W'(WB_LAT);
      end
   end

   always_comb begin
      fc_d = fc_q;
      if (hz.br_taken)     fc_d = FC_W'(FLUSH_LEN);
      else if (fc_q != '0) fc_d = fc_q - FC_W'(1);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_w && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (hz.br_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         for (int r = 0; r < 32; r++) begin
            sb_q[r] <= '0;
         end
         fc_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            sb_q[r] <= sb_d[r];
         end
         fc_q        <= fc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall     = stall_w;
   assign hz.flush     = flush_w;
   assign hz.issue     = issue_w;
   assign hz.busy_mask = busy_w;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl with a timing-level reference model and scoreboard.
module tb_pipe_hazard_ctrl;
   localparam int WB_LAT    = 3;
   localparam int FLUSH_LEN = 2;
   localparam int CNT_W     = 16;

   logic clk = 1'b0;
   logic RN  = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(.WB_LAT(WB_LAT), .FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .RN (RN),
      .hz (hz)
   );

   typedef struct packed {
      logic             stall;
      logic             flush;
      logic             issue;
      logic [31:0]      bm;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // reference model: cycle n = edges since time 0; a write issued in cycle n is visible
   // from cycle n+WB_LAT+1; a branch pulse in cycle b flushes cycles b+1..b+FLUSH_LEN
   int   cyc = 0;
   int   free_at [32];
   int   last_br = -100;
   int   scnt = 0, fcnt = 0;
   bit   prev_rn = 0, prev_br = 0, prev_stall = 0, prev_issue = 0;
   logic [31:0] prev_ir = '0;

   function automatic logic [31:0] mk(input int typ, input int rd, input int f3, input int rs1, input int rs2);
      logic [31:0] ir;
      ir = '0;
      ir[6:0]   = 7'(typ);
      ir[11:7]  = 5'(rd);
      ir[14:12] = 3'(f3);
      ir[19:15] = 5'(rs1);
      ir[24:20] = 5'(rs2);
      return ir;
   endfunction

   function automatic bit writes(input logic [31:0] ir);
      return (ir[6:0] == 7'd0) || (ir[6:0] == 7'd3) || (ir[6:0] == 7'd1 && ir[14:12] == 3'd0);
   endfunction

   function automatic logic [31:0] reads(input logic [31:0] ir);
      logic [31:0] m;
      m = '0;
      if (ir[6:0] == 7'd0 || ir[6:0] == 7'd3) begin
         m[ir[19:15]] = 1'b1; m[ir[24:20]] = 1'b1;
      end else if (ir[6:0] == 7'd1 && ir[14:12] == 3'd0) begin
         m[ir[19:15]] = 1'b1;
      end else if (ir[6:0] == 7'd1 && ir[14:12] == 3'd1) begin
         m[ir[19:15]] = 1'b1; m[ir[24:20]] = 1'b1; m[ir[11:7]] = 1'b1;
      end
      m[0] = 1'b0;
      return m;
   endfunction

   function automatic int sat_inc(input int v);
      return (v == (1 << CNT_W) - 1) ? v : v + 1;
   endfunction

   task automatic model_edge();
      if (prev_rn) begin
         if (prev_issue && writes(prev_ir) && prev_ir[11:7] != 5'd0)
            free_at[prev_ir[11:7]] = cyc + WB_LAT + 1;
         if (prev_br) begin
            last_br = cyc;
            fcnt    = sat_inc(fcnt);
         end
         if (prev_stall) scnt = sat_inc(scnt);
      end
      cyc++;
   endtask

   // one cycle: apply inputs just after the edge, predict outputs, queue the prediction
   task automatic step(input bit rn, input bit v, input logic [31:0] ir, input bit br);
      exp_t        e;
      logic [31:0] busy;
      bit          fl, st;
      @(posedge clk);
      model_edge();
      #1;
      RN          = rn;
      hz.id_valid = v;
      hz.id_ir    = ir;
      hz.br_taken = br;
      if (!rn) begin
         foreach (free_at[r]) free_at[r] = 0;
         last_br = -100;
         scnt = 0;
         fcnt = 0;
      end
      busy = '0;
      for (int r = 1; r < 32; r++) busy[r] = (cyc < free_at[r]);
      fl = rn && (cyc > last_br) && (cyc <= last_br + FLUSH_LEN);
      st = v && !fl && ((reads(ir) & busy) != '0);
      e.stall = st;
      e.flush = fl;
      e.issue = v && !st && !fl && !br;
      e.bm    = busy;
      e.sc    = CNT_W'(scnt);
      e.fc    = CNT_W'(fcnt);
      exp_q.push_back(e);
      prev_rn = rn; prev_br = br; prev_stall = st; prev_issue = e.issue; prev_ir = ir;
   endtask

   // monitor: outputs are presented every cycle, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = '{hz.stall, hz.flush, hz.issue, hz.busy_mask, hz.stall_cnt, hz.flush_cnt};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL cyc%0d outputs: got stall=%b flush=%b issue=%b busy=%h scnt=%0d fcnt=%0d, want stall=%b flush=%b issue=%b busy=%h scnt=%0d fcnt=%0d",
                     cyc, a.stall, a.flush, a.issue, a.bm, a.sc, a.fc,
                     e.stall, e.flush, e.issue, e.bm, e.sc, e.fc);
         end
      end
   end

   logic [31:0] ir;
   bit          keep;

   initial begin
      foreach (free_at[r]) free_at[r] = 0;
      hz.id_valid = 1'b0;
      hz.id_ir    = '0;
      hz.br_taken = 1'b0;

      step(0, 0, '0, 0);
      step(0, 1, mk(0, 6, 0, 1, 2), 0);
      step(1, 0, '0, 0);

      // RAW: add r6,r1,r2 ; add r7,r6,r6 held until issued
      step(1, 1, mk(0, 6, 0, 1, 2), 0);
      repeat (4) step(1, 1, mk(0, 7, 0, 6, 6), 0);
      step(1, 0, '0, 0);
      // independent: sub r7,r1,r2 ; or r9,r2,r5
      step(1, 1, mk(0, 7, 0, 1, 2), 0);
      step(1, 1, mk(3, 9, 6, 2, 5), 0);
      repeat (4) step(1, 0, '0, 0);
      // load-use via store data, then r0 reads
      step(1, 1, mk(1, 13, 0, 1, 2), 0);
      repeat (4) step(1, 1, mk(1, 13, 1, 1, 0), 0);
      step(1, 1, mk(0, 0, 0, 0, 0), 0);
      step(1, 1, mk(0, 5, 0, 0, 0), 0);
      // taken branch: successors are killed and set no busy bits
      step(1, 1, mk(2, 0, 0, 3, 4), 0);
      step(1, 1, mk(0, 20, 0, 1, 1), 1);
      step(1, 1, mk(0, 21, 0, 1, 1), 0);
      step(1, 1, mk(0, 22, 0, 1, 1), 0);
      step(1, 1, mk(0, 23, 0, 1, 1), 0);
      // reset mid-run with registers busy
      step(1, 1, mk(0, 3, 0, 1, 2), 0);
      step(0, 1, mk(0, 4, 0, 3, 3), 0);
      step(0, 1, mk(0, 4, 0, 3, 3), 0);
      step(1, 0, '0, 0);
      // branch during a stall, second pulse inside the flush window
      step(1, 1, mk(0, 6, 0, 1, 2), 0);
      step(1, 1, mk(0, 7, 0, 6, 6), 0);
      step(1, 1, mk(0, 7, 0, 6, 6), 1);
      step(1, 1, mk(0, 7, 0, 6, 6), 0);
      step(1, 1, mk(0, 7, 0, 6, 6), 1);
      repeat (4) step(1, 1, mk(0, 8, 0, 6, 6), 0);

      // randomized traffic on a small register set to provoke hazards
      ir = mk(0, 1, 0, 2, 3);
      repeat (600) begin
         keep = (prev_stall && $urandom_range(0, 3) != 0);
         if (!keep)
            ir = mk($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 7), $urandom_range(0, 7));
         step($urandom_range(0, 149) != 0, $urandom_range(0, 4) != 0, ir,
              $urandom_range(0, 9) == 0);
      end

      @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
